// File: rtl/tqvp_bus_initiator.sv
// tqvp_bus_initiator
//   Host side of the TinyQV peripheral data bus. It takes one command at a
//   time over a valid/ready handshake and drives address, data and strobe
//   onto a tqvp_* peripheral. It waits for data_ready, with an optional
//   timeout, and then returns a response over a second valid/ready handshake.
//   All outputs are registered.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_write, cmd_size, cmd_addr  command fields (size 11 = illegal)
//   cmd_wdata                      write data, driven in full on data_out
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_err             size-masked read data / timeout-or-illegal flag
//   address, data_out              to peripheral
//   data_write_n, data_read_n      to peripheral strobes, 11 = idle
//   data_in, data_ready            from peripheral
//   busy                           transaction in flight (state != IDLE)

module tqvp_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  address,
    output logic [31:0] data_out,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_in,
    input  logic        data_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W+1)'(TIMEOUT_CYCLES);

    state_t      state_q,     state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q,      busy_d;
    logic [5:0]  addr_q,      addr_d;
    logic [31:0] dout_q,      dout_d;
    logic [1:0]  wr_n_q,      wr_n_d;
    logic [1:0]  rd_n_q,      rd_n_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        err_q,       err_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [1:0]  size_q,      size_d;
    logic        write_q,     write_d;

    // Counter is one bit wider for the compare, so a timeout equal to the
    // counter's full range still matches.
    logic [CNT_W:0] cnt_inc;
    logic           timeout_hit;
    logic [31:0]    rd_masked;

    assign cnt_inc     = {1'b0, cnt_q} + 1'b1;
    // The cycle that brings the count to TIMEOUT_CYCLES is the last strobe
    // cycle. This gives exactly TIMEOUT_CYCLES strobe cycles without data_ready.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_VAL);

    always_comb begin
        case (size_q)
            2'b00:   rd_masked = {24'b0, data_in[7:0]};
            2'b01:   rd_masked = {16'b0, data_in[15:0]};
            default: rd_masked = data_in;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        wr_n_d      = wr_n_q;
        rd_n_d      = rd_n_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        write_d     = write_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    dout_d  = cmd_wdata;
                    size_d  = cmd_size;
                    write_d = cmd_write;
                    cnt_d   = '0;
                    if (cmd_size == 2'b11) begin
                        // Illegal size: the bus is never touched.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                        rdata_d     = '0;
                    end else begin
                        state_d = S_ACCESS;
                        if (cmd_write) wr_n_d = cmd_size;
                        else           rd_n_d = cmd_size;
                    end
                end
            end
            S_ACCESS: begin
                // data_ready takes priority over a timeout in the same cycle.
                if (data_ready) begin
                    wr_n_d      = 2'b11;
                    rd_n_d      = 2'b11;
                    rdata_d     = write_q ? 32'h0 : rd_masked;
                    err_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_inc[CNT_W-1:0];
                    if (timeout_hit) begin
                        wr_n_d      = 2'b11;
                        rd_n_d      = 2'b11;
                        rdata_d     = '0;
                        err_d       = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            wr_n_q      <= 2'b11;
            rd_n_q      <= 2'b11;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            write_q     <= write_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign address      = addr_q;
    assign data_out     = dout_q;
    assign data_write_n = wr_n_q;
    assign data_read_n  = rd_n_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Directed bench for tqvp_bus_initiator. Inputs are driven and outputs are
// sampled #1 after each rising edge.
module tb_tqvp_bus_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_size;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [5:0]  address;
    logic [31:0] data_out, data_in;
    logic [1:0]  data_write_n, data_read_n;
    logic        data_ready, busy;

    int errors = 0;
    int checks = 0;

    tqvp_bus_initiator #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .address(address), .data_out(data_out),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_in(data_in), .data_ready(data_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a command and waits for the accepting edge.
    task automatic send(input logic wr, input logic [1:0] sz, input logic [5:0] a, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_addr = a; cmd_wdata = d;
        chk("cmd_ready_before", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_size = 0; cmd_addr = 0;
        cmd_wdata = 0; rsp_ready = 0; data_in = 0; data_ready = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_wr_n",   {30'b0, data_write_n}, 32'h3);
        chk("rst_rd_n",   {30'b0, data_read_n},  32'h3);
        chk("rst_addr",   {26'b0, address},      32'h0);
        chk("rst_dout",   data_out,              32'h0);
        chk("rst_rvalid", {31'b0, rsp_valid},    32'h0);
        chk("rst_rdata",  rsp_rdata,             32'h0);
        chk("rst_err",    {31'b0, rsp_err},      32'h0);
        chk("rst_ready",  {31'b0, cmd_ready},    32'h1);
        chk("rst_busy",   {31'b0, busy},         32'h0);

        // 1: 32b write, data_ready tied high -> one strobe cycle
        data_ready = 1'b1;
        send(1'b1, 2'b10, 6'h00, 32'h6000_0005);
        chk("t1_wr_n",  {30'b0, data_write_n}, 32'h2);
        chk("t1_rd_n",  {30'b0, data_read_n},  32'h3);
        chk("t1_dout",  data_out,              32'h6000_0005);
        chk("t1_busy",  {31'b0, busy},         32'h1);
        chk("t1_nrv",   {31'b0, rsp_valid},    32'h0);
        tick();
        chk("t1_wr_off", {30'b0, data_write_n}, 32'h3);
        chk("t1_rvalid", {31'b0, rsp_valid},    32'h1);
        chk("t1_err",    {31'b0, rsp_err},      32'h0);
        chk("t1_rdata",  rsp_rdata,             32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t1_done", {31'b0, rsp_valid}, 32'h0);
        chk("t1_idle", {31'b0, cmd_ready}, 32'h1);

        // 2: 8b read, data_ready in the third strobe cycle
        data_ready = 1'b0; data_in = 32'hDEAD_BE7A;
        send(1'b0, 2'b00, 6'h18, 32'h0);
        chk("t2_addr", {26'b0, address}, 32'h18);
        for (int i = 0; i < 3; i++) begin
            chk("t2_rd_n", {30'b0, data_read_n},  32'h0);
            chk("t2_wr_n", {30'b0, data_write_n}, 32'h3);
            if (i == 2) data_ready = 1'b1;
            tick();
        end
        data_ready = 1'b0;
        chk("t2_rd_off", {30'b0, data_read_n}, 32'h3);
        chk("t2_rvalid", {31'b0, rsp_valid},   32'h1);
        chk("t2_rdata",  rsp_rdata,            32'h0000_007A);
        chk("t2_err",    {31'b0, rsp_err},     32'h0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // 3: 16b read, no data_ready -> timeout after 16 strobe cycles
        data_in = 32'h1234_5678;
        send(1'b0, 2'b01, 6'h04, 32'h0);
        for (int i = 0; i < 16; i++) begin
            chk("t3_rd_n", {30'b0, data_read_n}, 32'h1);
            tick();
        end
        chk("t3_rd_off", {30'b0, data_read_n}, 32'h3);
        chk("t3_rvalid", {31'b0, rsp_valid},   32'h1);
        chk("t3_err",    {31'b0, rsp_err},     32'h1);
        chk("t3_rdata",  rsp_rdata,            32'h0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // 4: illegal size -> immediate error response, no strobe
        send(1'b1, 2'b11, 6'h08, 32'hFFFF_FFFF);
        chk("t4_wr_n",   {30'b0, data_write_n}, 32'h3);
        chk("t4_rd_n",   {30'b0, data_read_n},  32'h3);
        chk("t4_rvalid", {31'b0, rsp_valid},    32'h1);
        chk("t4_err",    {31'b0, rsp_err},      32'h1);
        chk("t4_rdata",  rsp_rdata,             32'h0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // 5: response back-pressure with a new command pending
        data_ready = 1'b1; data_in = 32'hCAFE_F00D;
        send(1'b0, 2'b10, 6'h10, 32'h0);
        chk("t5_rd_n", {30'b0, data_read_n}, 32'h2);
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 2'b00;
        cmd_addr = 6'h20; cmd_wdata = 32'h0000_00AB;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_rv",  {31'b0, rsp_valid},    32'h1);
            chk("t5_hold_rd",  rsp_rdata,             32'hCAFE_F00D);
            chk("t5_hold_crd", {31'b0, cmd_ready},    32'h0);
            chk("t5_hold_wr",  {30'b0, data_write_n}, 32'h3);
            chk("t5_hold_rdn", {30'b0, data_read_n},  32'h3);
            tick();
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        chk("t5_gap_wr", {30'b0, data_write_n}, 32'h3);
        chk("t5_gap_rv", {31'b0, rsp_valid},    32'h0);
        chk("t5_gap_cr", {31'b0, cmd_ready},    32'h1);
        tick();
        cmd_valid = 1'b0;
        chk("t5_next_wr",   {30'b0, data_write_n}, 32'h0);
        chk("t5_next_addr", {26'b0, address},      32'h20);
        tick();
        chk("t5_next_rv", {31'b0, rsp_valid}, 32'h1);
        chk("t5_next_rd", rsp_rdata,          32'h0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // 6: reset mid-access discards the transaction
        data_ready = 1'b0;
        send(1'b0, 2'b10, 6'h0C, 32'h0);
        tick();
        chk("t6_rd_n", {30'b0, data_read_n}, 32'h2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rd_off", {30'b0, data_read_n}, 32'h3);
        chk("t6_rv0",    {31'b0, rsp_valid},   32'h0);
        data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_rsp", {31'b0, rsp_valid}, 32'h0);
        end
        send(1'b1, 2'b01, 6'h02, 32'h0000_BEEF);
        chk("t6_wr_n", {30'b0, data_write_n}, 32'h1);
        tick();
        chk("t6_rv",  {31'b0, rsp_valid}, 32'h1);
        chk("t6_err", {31'b0, rsp_err},   32'h0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        chk("t6_idle", {31'b0, busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
